// File: rtl/prng_pkg.sv
// Shared PRNG definitions: LFSR width, reset value, tap function and arbiter states.
package prng_pkg;

  localparam int LFSR_W = 8;
  localparam logic [LFSR_W-1:0] LFSR_RESET = 8'h01;

  typedef enum logic {
    WARMUP = 1'b0,
    SERVE  = 1'b1
  } arb_state_e;

  function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] s);
    return {s[6:0], s[7] ^ s[5] ^ s[4] ^ s[3]};
  endfunction

endpackage

// File: rtl/prng_lfsr_core.sv
// 8-bit Fibonacci LFSR register with load and advance controls.
// A zero load value is forced to LFSR_RESET, since all-zero is a lock-up state.
module prng_lfsr_core
  import prng_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic [LFSR_W-1:0] load_data,
  input  logic              advance,
  output logic [LFSR_W-1:0] state
);

  logic [LFSR_W-1:0] state_r;

  // LFSR state update: load has priority over advance
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= LFSR_RESET;
    end else if (load) begin
      state_r <= (load_data == {LFSR_W{1'b0}}) ? LFSR_RESET : load_data;
    end else if (advance) begin
      state_r <= lfsr_next(state_r);
    end else begin
      state_r <= state_r;
    end
  end

  assign state = state_r;

endmodule

// File: rtl/prng_arbiter.sv
// Round-robin arbiter sharing one LFSR; each grant consumes exactly one LFSR step.
// Optional macro PRNG_ARB_STATS_EN adds a saturating 16-bit grant_count output.
module prng_arbiter
  import prng_pkg::*;
#(
  parameter int NUM_REQ       = 4,
  parameter int WARMUP_CYCLES = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_REQ-1:0] req,
  input  logic               seed_valid,
  input  logic [LFSR_W-1:0]  seed_data,
  output logic [NUM_REQ-1:0] gnt,
  output logic [LFSR_W-1:0]  rnd_data,
  output logic               ready
`ifdef PRNG_ARB_STATS_EN
  ,
  output logic [15:0]        grant_count
`endif
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [7:0] WARM_INIT = 8'(WARMUP_CYCLES);
  localparam arb_state_e START_STATE = (WARMUP_CYCLES == 0) ? SERVE : WARMUP;
  localparam logic [NUM_REQ-1:0] ONE_HOT0 = {{(NUM_REQ-1){1'b0}}, 1'b1};

  arb_state_e         state_r, state_next_s;
  logic [7:0]         cnt_r;
  logic [PTR_W-1:0]   ptr_r;
  logic [LFSR_W-1:0]  lfsr_s;
  logic               advance_s, issue_s, grant_valid_s;
  logic [PTR_W-1:0]   grant_idx_s;
  int                 cand_s;
  logic [NUM_REQ-1:0] gnt_r;
  logic [LFSR_W-1:0]  rnd_r;
  logic               ready_r;

  prng_lfsr_core u_lfsr (
    .clk       (clk),
    .reset     (reset),
    .load      (seed_valid),
    .load_data (seed_data),
    .advance   (advance_s),
    .state     (lfsr_s)
  );

  // FSM state register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= START_STATE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // FSM next-state logic; a seed restarts warm-up from any state
  always_comb begin
    state_next_s = state_r;
    if (seed_valid) begin
      state_next_s = START_STATE;
    end else begin
      case (state_r)
        WARMUP:  state_next_s = (cnt_r <= 8'd1) ? SERVE : WARMUP;
        SERVE:   state_next_s = SERVE;
        default: state_next_s = START_STATE;
      endcase
    end
  end

  // Warm-up counter: reloaded on reset or seed, counts down while warming
  always_ff @(posedge clk) begin
    if (reset || seed_valid) begin
      cnt_r <= WARM_INIT;
    end else if (state_r == WARMUP && cnt_r != 8'd0) begin
      cnt_r <= cnt_r - 8'd1;
    end else begin
      cnt_r <= cnt_r;
    end
  end

  // Round-robin search starting just after the last granted requester
  always_comb begin
    grant_valid_s = 1'b0;
    grant_idx_s   = {PTR_W{1'b0}};
    cand_s        = 0;
    for (int i = 0; i < NUM_REQ; i++) begin
      cand_s = int'(ptr_r) + 1 + i;
      if (cand_s >= NUM_REQ) begin
        cand_s = cand_s - NUM_REQ;
      end else begin
        cand_s = cand_s;
      end
      if (!grant_valid_s && req[cand_s]) begin
        grant_valid_s = 1'b1;
        grant_idx_s   = PTR_W'(cand_s);
      end else begin
        grant_valid_s = grant_valid_s;
      end
    end
  end

  // FSM output decode: LFSR advance and grant issue
  always_comb begin
    advance_s = 1'b0;
    issue_s   = 1'b0;
    case (state_r)
      WARMUP: begin
        advance_s = !seed_valid;
      end
      SERVE: begin
        issue_s   = !seed_valid && grant_valid_s;
        advance_s = !seed_valid && grant_valid_s;
      end
      default: begin
        advance_s = 1'b0;
        issue_s   = 1'b0;
      end
    endcase
  end

  // Registered outputs and round-robin pointer
  always_ff @(posedge clk) begin
    if (reset) begin
      gnt_r   <= {NUM_REQ{1'b0}};
      rnd_r   <= 8'h00;
      ready_r <= 1'b0;
      ptr_r   <= PTR_W'(NUM_REQ - 1);
    end else begin
      gnt_r   <= issue_s ? (ONE_HOT0 << grant_idx_s) : {NUM_REQ{1'b0}};
      rnd_r   <= issue_s ? lfsr_s : rnd_r;
      ptr_r   <= issue_s ? grant_idx_s : ptr_r;
      ready_r <= (state_next_s == SERVE);
    end
  end

  assign gnt      = gnt_r;
  assign rnd_data = rnd_r;
  assign ready    = ready_r;

`ifdef PRNG_ARB_STATS_EN
  logic [15:0] grant_count_r;

  // Saturating grant counter, cleared by reset or seed
  always_ff @(posedge clk) begin
    if (reset || seed_valid) begin
      grant_count_r <= 16'h0000;
    end else if (issue_s && grant_count_r != 16'hFFFF) begin
      grant_count_r <= grant_count_r + 16'h0001;
    end else begin
      grant_count_r <= grant_count_r;
    end
  end

  assign grant_count = grant_count_r;
`endif

endmodule

// File: tb/tb_prng_arbiter.sv
// Scoreboard bench for prng_arbiter: a behavioural model predicts each cycle's outputs.
module tb_prng_arbiter;

  localparam int N = 4;
  localparam int W = 8;

  logic         clk;
  logic         reset;
  logic [N-1:0] req;
  logic         seed_valid;
  logic [7:0]   seed_data;
  logic [N-1:0] gnt;
  logic [7:0]   rnd_data;
  logic         ready;
`ifdef PRNG_ARB_STATS_EN
  logic [15:0]  grant_count;
`endif

  prng_arbiter #(.NUM_REQ(N), .WARMUP_CYCLES(W)) dut (
    .clk        (clk),
    .reset      (reset),
    .req        (req),
    .seed_valid (seed_valid),
    .seed_data  (seed_data),
    .gnt        (gnt),
    .rnd_data   (rnd_data),
    .ready      (ready)
`ifdef PRNG_ARB_STATS_EN
    ,
    .grant_count(grant_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [N-1:0] gnt;
    logic [7:0]   rnd;
    logic         rdy;
  } exp_t;

  exp_t sbq[$];
  int   n_checks = 0;
  int   n_errors = 0;

  // behavioural reference state
  bit [7:0] m_lfsr;
  int       m_cnt;
  bit       m_serve;
  int       m_ptr;
  bit [7:0] m_rnd;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit [7:0] m_next(input bit [7:0] s);
    bit fb;
    fb = ^(s & 8'b1011_1000);
    return {s[6:0], fb};
  endfunction

  // Predict the outputs produced by the coming edge and queue them
  task automatic model_step();
    exp_t e;
    e.gnt = '0;
    if (reset) begin
      m_lfsr = 8'h01; m_cnt = W; m_serve = (W == 0); m_ptr = N - 1; m_rnd = 8'h00;
      e.rdy = 1'b0;
    end else begin
      if (seed_valid) begin
        m_lfsr = (seed_data == 8'h00) ? 8'h01 : seed_data;
        m_cnt = W; m_serve = (W == 0);
      end else if (!m_serve) begin
        m_lfsr = m_next(m_lfsr);
        m_cnt--;
        if (m_cnt == 0) m_serve = 1'b1;
      end else if (req != '0) begin
        for (int k = 1; k <= N; k++) begin
          int c;
          c = (m_ptr + k) % N;
          if (req[c]) begin
            e.gnt = N'(1) << c;
            m_rnd = m_lfsr;
            m_lfsr = m_next(m_lfsr);
            m_ptr = c;
            break;
          end
        end
      end
      e.rdy = m_serve;
    end
    e.rnd = m_rnd;
    sbq.push_back(e);
  endtask

  task automatic tick();
    exp_t e;
    model_step();
    @(posedge clk);
    #1;
    e = sbq.pop_front();
    check_val("sb_gnt", 32'(gnt), 32'(e.gnt));
    check_val("sb_rnd", 32'(rnd_data), 32'(e.rnd));
    check_val("sb_ready", 32'(ready), 32'(e.rdy));
  endtask

  task automatic wait_ready(input string tag);
    int n;
    n = 0;
    while (ready !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    check_val(tag, 32'(n), 32'(W));
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  logic [7:0] seen[$];
  logic [N-1:0] rr_exp[5];
  int dup;

  initial begin
    reset = 1'b1; req = '0; seed_valid = 1'b0; seed_data = 8'h00;
    rr_exp[0] = 4'b0001; rr_exp[1] = 4'b0010; rr_exp[2] = 4'b0100;
    rr_exp[3] = 4'b1000; rr_exp[4] = 4'b0001;

    // reset state and warm-up length
    do_reset();
    check_val("rst_gnt", 32'(gnt), 32'h0);
    check_val("rst_rnd", 32'(rnd_data), 32'h0);
    check_val("rst_ready", 32'(ready), 32'h0);
    wait_ready("warmup_len");

    // single requester, two separate requests
    req = 4'b0001; tick();
    check_val("single_gnt", 32'(gnt), 32'h1);
    check_val("single_rnd", 32'(rnd_data), 32'h1C);
    req = '0; tick();
    check_val("idle_gnt", 32'(gnt), 32'h0);
    check_val("idle_rnd_hold", 32'(rnd_data), 32'h1C);
    req = 4'b0001; tick();
    check_val("second_rnd", 32'(rnd_data), 32'h38);
    req = '0; tick();

    // all requesters held: strict rotation with distinct draws
    do_reset();
    wait_ready("warmup_len2");
    req = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      tick();
      check_val($sformatf("rr_gnt%0d", i), 32'(gnt), 32'(rr_exp[i]));
      dup = 0;
      foreach (seen[j]) if (seen[j] == rnd_data) dup++;
      check_val($sformatf("rr_distinct%0d", i), 32'(dup), 32'h0);
      seen.push_back(rnd_data);
    end
    req = '0; tick();

    // zero seed with a pending request
    seed_valid = 1'b1; seed_data = 8'h00; req = 4'b0010; tick();
    check_val("seed_gnt", 32'(gnt), 32'h0);
    check_val("seed_ready", 32'(ready), 32'h0);
    seed_valid = 1'b0;
    wait_ready("seed_warmup_len");
    tick();
    check_val("seed_first_gnt", 32'(gnt), 32'h2);
    check_val("seed_first_rnd", 32'(rnd_data), 32'h1C);
    req = '0; tick();

    // reset beats seed and request in the same cycle
    req = 4'b1111; tick();
    reset = 1'b1; seed_valid = 1'b1; seed_data = 8'h5A; tick();
    check_val("rst_win_gnt", 32'(gnt), 32'h0);
    check_val("rst_win_rnd", 32'(rnd_data), 32'h0);
    check_val("rst_win_ready", 32'(ready), 32'h0);
    reset = 1'b0; seed_valid = 1'b0; req = '0;
    wait_ready("post_rst_warmup");

`ifdef PRNG_ARB_STATS_EN
    req = 4'b1111;
    for (int i = 0; i < 5; i++) tick();
    req = '0; tick();
    check_val("stats_count", 32'(grant_count), 32'd5);
    seed_valid = 1'b1; seed_data = 8'h33; tick();
    seed_valid = 1'b0;
    check_val("stats_clear", 32'(grant_count), 32'd0);
`endif

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
